// File: rtl/mul_pkg.sv
// Shared types and constants for the multi-cycle multiplier and its ALU-facing encoding.
package mul_pkg;

  localparam int MUL_WIDTH = 32;
  localparam int MUL_CNT_W = 6;

  // Matches ALU f[3]: mult = 1, multu = 0.
  localparam logic MUL_SIGNED   = 1'b1;
  localparam logic MUL_UNSIGNED = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } mul_state_t;

endpackage

// File: rtl/mul_abs_neg.sv
// Conditional two's-complement, combinational: o_dat = i_neg ? -i_dat : i_dat.
// Used as |x| on operand capture and as the final sign fix-up on the product.
module mul_abs_neg #(
  parameter int W = 32
) (
  input  logic         i_neg,
  input  logic [W-1:0] i_dat,
  output logic [W-1:0] o_dat
);

  assign o_dat = i_neg ? (~i_dat + W'(1)) : i_dat;

endmodule

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add 32x32 multiplier with HI/LO registers; start->done is 34 cycles.
// No backpressure: start is only accepted in IDLE/DONE and silently dropped while busy.
module seq_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int CNT_W = MUL_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               hi_we,
  input  logic               lo_we,
  input  logic [WIDTH-1:0]   wdata,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic [2*WIDTH-1:0] mulout
);

  mul_state_t         r_state;
  mul_state_t         w_state_nxt;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_neg;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_accept;
  logic               w_calc_last;
  logic               w_signed;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_prod;

  assign w_signed    = (is_signed == MUL_SIGNED);
  assign w_accept    = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_calc_last = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_sum       = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand};

  // Magnitudes are multiplied unsigned; 0x80000000 stays 0x80000000 and is read as 2^31.
  mul_abs_neg #(.W(WIDTH)) u_abs_a (
    .i_neg (w_signed & a[WIDTH-1]),
    .i_dat (a),
    .o_dat (w_abs_a)
  );

  mul_abs_neg #(.W(WIDTH)) u_abs_b (
    .i_neg (w_signed & b[WIDTH-1]),
    .i_dat (b),
    .o_dat (w_abs_b)
  );

  mul_abs_neg #(.W(2*WIDTH)) u_neg_p (
    .i_neg (r_neg),
    .i_dat (r_acc),
    .o_dat (w_prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = CALC;
      CALC:    if (w_calc_last) w_state_nxt = SIGN;
      SIGN:    w_state_nxt = DONE;
      DONE:    w_state_nxt = start ? CALC : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
    end else if (w_accept) begin
      r_mcand  <= w_abs_a;
      r_mplier <= w_abs_b;
      r_neg    <= w_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (r_state == CALC) begin
      // The add's carry-out becomes the top bit after the right shift.
      if (r_mplier[0]) begin
        r_acc <= {w_sum, r_acc[WIDTH-1:1]};
      end else begin
        r_acc <= {1'b0, r_acc[2*WIDTH-1:1]};
      end
      r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
      r_cnt    <= r_cnt + CNT_W'(1);
    end
  end

  // The SIGN-cycle result takes priority over a coincident mthi/mtlo.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (r_state == SIGN) begin
      r_hi <= w_prod[2*WIDTH-1:WIDTH];
      r_lo <= w_prod[WIDTH-1:0];
    end else begin
      if (hi_we) r_hi <= wdata;
      if (lo_we) r_lo <= wdata;
    end
  end

  assign busy   = (r_state == CALC) || (r_state == SIGN);
  assign done   = (r_state == DONE);
  assign hi     = r_hi;
  assign lo     = r_lo;
  assign mulout = {r_hi, r_lo};

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: products, latency, HI/LO writes, ignored starts, reset abort.
module tb_seq_multiplier;
  import mul_pkg::*;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          is_signed = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          hi_we = 1'b0;
  logic          lo_we = 1'b0;
  logic [W-1:0]  wdata = '0;
  logic          busy;
  logic          done;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;
  logic [2*W-1:0] mulout;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] sb_q[$];

  always #5 clk = ~clk;

  seq_multiplier #(.WIDTH(32), .CNT_W(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .hi_we     (hi_we),
    .lo_we     (lo_we),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo),
    .mulout    (mulout)
  );

  // Reference: extend to 64 bits and multiply modulo 2^64.
  function automatic logic [63:0] model(input logic sgn, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] ex;
    logic [63:0] ey;
    ex = sgn ? {{32{x[31]}}, x} : {32'b0, x};
    ey = sgn ? {{32{y[31]}}, y} : {32'b0, y};
    return ex * ey;
  endfunction

  // Returns at the falling edge of cycle k+1 (k = edge that sampled start).
  task automatic pulse_start(input logic sgn, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; is_signed = sgn; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int bcnt, output bit got);
    lat = 1; bcnt = 0; got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if (mulout !== 64'h0) begin n_err++; $display("FAIL reset_mulout: got %h expected %h", mulout, 64'h0); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL post_reset_idle: got busy/done %b expected 00", {busy, done}); end
  endtask

  task automatic test_one_mul(input string tag, input logic sgn, input logic [31:0] x,
                              input logic [31:0] y, input logic [63:0] exp);
    int lat; int bcnt; bit got;
    logic [63:0] e;
    sb_q.push_back(exp);
    pulse_start(sgn, x, y);
    wait_done(lat, bcnt, got);
    e = sb_q.pop_front();
    n_vec++;
    if (!got) begin
      n_err++; $display("FAIL %s_timeout: no done after %0d cycles", tag, lat);
    end else begin
      n_vec++; if (lat !== 34) begin n_err++; $display("FAIL %s_latency: got %0d expected 34", tag, lat); end
      n_vec++; if (bcnt !== 33) begin n_err++; $display("FAIL %s_busy_cycles: got %0d expected 33", tag, bcnt); end
      n_vec++; if (mulout !== e) begin n_err++; $display("FAIL %s_mulout: got %h expected %h", tag, mulout, e); end
      n_vec++; if ({hi, lo} !== e) begin n_err++; $display("FAIL %s_hilo: got %h_%h expected %h", tag, hi, lo, e); end
      @(negedge clk);
      n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL %s_done_pulse: got %b expected 0", tag, done); end
    end
  endtask

  task automatic test_unsigned();
    logic [31:0] x; logic [31:0] y;
    test_one_mul("u_small", MUL_UNSIGNED, 32'd3, 32'd5, 64'h0000_0000_0000_000F);
    test_one_mul("u_max", MUL_UNSIGNED, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    test_one_mul("u_zero", MUL_UNSIGNED, 32'hDEAD_BEEF, 32'h0, 64'h0);
    test_one_mul("u_msb", MUL_UNSIGNED, 32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000);
    for (int i = 0; i < 3; i++) begin
      x = $urandom; y = $urandom;
      test_one_mul("u_rand", MUL_UNSIGNED, x, y, model(1'b0, x, y));
    end
  endtask

  task automatic test_signed();
    logic [31:0] x; logic [31:0] y;
    test_one_mul("s_mixed", MUL_SIGNED, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA);
    test_one_mul("s_minmin", MUL_SIGNED, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    test_one_mul("s_m1m1", MUL_SIGNED, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
    test_one_mul("s_maxmin", MUL_SIGNED, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000);
    for (int i = 0; i < 3; i++) begin
      x = $urandom; y = $urandom;
      test_one_mul("s_rand", MUL_SIGNED, x, y, model(1'b1, x, y));
    end
  endtask

  task automatic test_mthi_mtlo();
    logic [31:0] lo_before;
    lo_before = lo;
    @(negedge clk); hi_we = 1'b1; wdata = 32'h1234_5678;
    @(negedge clk); hi_we = 1'b0;
    n_vec++; if (hi !== 32'h1234_5678) begin n_err++; $display("FAIL mthi: got %h expected %h", hi, 32'h1234_5678); end
    n_vec++; if (lo !== lo_before) begin n_err++; $display("FAIL mthi_lo_kept: got %h expected %h", lo, lo_before); end
    lo_we = 1'b1; wdata = 32'hCAFE_F00D;
    @(negedge clk); lo_we = 1'b0;
    n_vec++; if ({hi, lo} !== 64'h1234_5678_CAFE_F00D) begin n_err++; $display("FAIL mtlo: got %h_%h expected 12345678_cafef00d", hi, lo); end
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0F0F_0F0F;
    @(negedge clk); hi_we = 1'b0; lo_we = 1'b0;
    n_vec++; if (mulout !== 64'h0F0F_0F0F_0F0F_0F0F) begin n_err++; $display("FAIL mthi_mtlo_both: got %h expected 0f0f0f0f0f0f0f0f", mulout); end
  endtask

  task automatic test_write_collision();
    logic [63:0] e;
    sb_q.push_back(model(1'b1, 32'hFFFF_FFFE, 32'd3));
    pulse_start(MUL_SIGNED, 32'hFFFF_FFFE, 32'd3);
    repeat (4) @(negedge clk);
    hi_we = 1'b1; wdata = 32'hAAAA_5555;
    @(negedge clk); hi_we = 1'b0;
    n_vec++; if (hi !== 32'hAAAA_5555) begin n_err++; $display("FAIL mthi_in_calc: got %h expected aaaa5555", hi); end
    repeat (27) @(negedge clk);
    n_vec++; if ({busy, done} !== 2'b10) begin n_err++; $display("FAIL sign_cycle_state: got busy/done %b expected 10", {busy, done}); end
    lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(negedge clk); lo_we = 1'b0;
    e = sb_q.pop_front();
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL collision_done: got %b expected 1", done); end
    n_vec++; if ({hi, lo} !== e) begin n_err++; $display("FAIL collision_result: got %h_%h expected %h", hi, lo, e); end
    @(negedge clk);
  endtask

  task automatic test_start_while_busy();
    int n_done; int first_lat; int lat;
    logic [63:0] e;
    sb_q.push_back(model(1'b0, 32'd11, 32'd13));
    pulse_start(MUL_UNSIGNED, 32'd11, 32'd13);
    lat = 1;
    repeat (8) @(negedge clk);
    lat = 9;
    start = 1'b1; a = 32'd7; b = 32'd7;
    n_done = 0; first_lat = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (done) begin
        n_done++;
        if (first_lat == 0) begin
          first_lat = lat;
          e = sb_q.pop_front();
          n_vec++; if (mulout !== e) begin n_err++; $display("FAIL busy_start_result: got %h expected %h", mulout, e); end
        end
      end
    end
    n_vec++; if (n_done !== 1) begin n_err++; $display("FAIL busy_start_done_count: got %0d expected 1", n_done); end
    n_vec++; if (first_lat !== 34) begin n_err++; $display("FAIL busy_start_latency: got %0d expected 34", first_lat); end
  endtask

  task automatic test_back_to_back();
    int lat; int bcnt; bit got;
    logic [63:0] e;
    sb_q.push_back(model(1'b1, 32'hFFFF_FFF9, 32'd6));
    pulse_start(MUL_SIGNED, 32'hFFFF_FFF9, 32'd6);
    wait_done(lat, bcnt, got);
    e = sb_q.pop_front();
    n_vec++; if (!got || mulout !== e) begin n_err++; $display("FAIL b2b_first: got %h done_seen %0d expected %h", mulout, got, e); end
    sb_q.push_back(model(1'b0, 32'h0001_0001, 32'h0001_0001));
    start = 1'b1; is_signed = MUL_UNSIGNED; a = 32'h0001_0001; b = 32'h0001_0001;
    @(negedge clk); start = 1'b0;
    wait_done(lat, bcnt, got);
    e = sb_q.pop_front();
    n_vec++; if (!got || lat !== 34) begin n_err++; $display("FAIL b2b_latency: got %0d done_seen %0d expected 34", lat, got); end
    n_vec++; if (mulout !== e) begin n_err++; $display("FAIL b2b_second: got %h expected %h", mulout, e); end
    @(negedge clk);
  endtask

  task automatic test_reset_midop();
    int n_done;
    pulse_start(MUL_SIGNED, 32'h1234_5678, 32'h8765_4321);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++; if ({hi, lo} !== 64'h0) begin n_err++; $display("FAIL midop_reset_hilo: got %h_%h expected 0", hi, lo); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL midop_reset_busy: got %b expected 0", busy); end
    @(negedge clk); rst_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    n_vec++; if (n_done !== 0) begin n_err++; $display("FAIL midop_reset_no_done: got %0d pulses expected 0", n_done); end
    test_one_mul("after_reset", MUL_UNSIGNED, 32'd100, 32'd200, 64'd20000);
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_mthi_mtlo();
    test_write_collision();
    test_start_while_busy();
    test_back_to_back();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
